// File: rtl/hazard_scoreboard_fwd.sv
// rtl/hazard_scoreboard_fwd.sv - ID/EX hazard unit: multi-stage forwarding, load-use stall, long-op scoreboard, stall watchdog
// Optional SB_STALL_STATS_EN adds a saturating stall_cycles counter port.
module hazard_scoreboard_fwd #(
    parameter int NSTG = 2,
    parameter int NREG = 32,
    parameter int RW   = 5,
    parameter int FW   = 2,
    parameter int WDOG = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [RW-1:0]     id_rs1,
    input  logic [RW-1:0]     id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [RW-1:0]     id_rd,
    input  logic              id_we,
    input  logic              id_long,
    input  logic              ex_is_load,
    input  logic [RW-1:0]     ex_rd,
    input  logic [RW-1:0]     ex_rs1,
    input  logic [RW-1:0]     ex_rs2,
    input  logic              ex_use_rs1,
    input  logic              ex_use_rs2,
    input  logic [NSTG-1:0]   stg_we,
    input  logic [NSTG*RW-1:0] stg_rd,
    input  logic              lc_valid,
    input  logic [RW-1:0]     lc_rd,
    output logic              stall_id,
    output logic [FW-1:0]     rs1_fwd,
    output logic [FW-1:0]     rs2_fwd,
    output logic [NREG-1:0]   pending,
    output logic              sb_timeout
`ifdef SB_STALL_STATS_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam int CW = (WDOG > 2) ? $clog2(WDOG) : 1;

    logic [0:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;
    logic [NREG-1:0] r_pending;

    logic            w_load_use;
    logic            w_raw1;
    logic            w_raw2;
    logic            w_waw;
    logic            w_sb_stall;
    logic            w_stall;
    logic            w_issue;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_pending_nxt;

    // Lowest (youngest) matching stage wins, so scan from oldest down and overwrite.
    function automatic logic [FW-1:0] fwd_sel(input logic use_src, input logic [RW-1:0] src,
                                              input logic [NSTG-1:0] we, input logic [NSTG*RW-1:0] rd);
        logic [FW-1:0] sel;
        sel = '0;
        if (use_src && src != '0) begin
            for (int i = NSTG - 1; i >= 0; i--) begin
                if (we[i] && rd[i*RW +: RW] == src) sel = FW'(i + 1);
            end
        end
        return sel;
    endfunction

    // A register completing via lc_* this cycle is covered by the WB forward, so it never stalls.
    function automatic logic sb_busy(input logic [RW-1:0] r);
        return r != '0 && r_pending[r] && !(lc_valid && lc_rd == r);
    endfunction

    always_comb begin
        w_load_use = ex_is_load && ex_rd != '0 &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        w_raw1     = id_use_rs1 && sb_busy(id_rs1);
        w_raw2     = id_use_rs2 && sb_busy(id_rs2);
        w_waw      = id_we && sb_busy(id_rd);
        w_sb_stall = !rst && id_valid && !flush && (w_raw1 || w_raw2 || w_waw);
        w_stall    = !rst && id_valid && !flush && (w_load_use || w_raw1 || w_raw2 || w_waw);
        w_issue    = id_valid && !w_stall && !flush;
    end

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_issue && id_we && id_long && id_rd != '0) w_set_mask[id_rd] = 1'b1;
        if (lc_valid) w_clr_mask[lc_rd] = 1'b1;
        // Set applied after clear: a new long writer beats the completing one.
        w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_sb_stall) r_state <= S_WAIT;
                end
                default: begin
                    if (!w_sb_stall || flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        if (r_cnt == CW'(WDOG - 1)) r_timeout <= 1'b1;
                        else                        r_cnt     <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef SB_STALL_STATS_EN
    logic [31:0] r_stall_cycles;
    always_ff @(posedge clk) begin
        if (rst)                                       r_stall_cycles <= '0;
        else if (w_stall && r_stall_cycles != '1)      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
    assign stall_cycles = r_stall_cycles;
`endif

    assign stall_id   = w_stall;
    assign rs1_fwd    = rst ? '0 : fwd_sel(ex_use_rs1, ex_rs1, stg_we, stg_rd);
    assign rs2_fwd    = rst ? '0 : fwd_sel(ex_use_rs2, ex_rs2, stg_we, stg_rd);
    assign pending    = r_pending;
    assign sb_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// tb/tb_hazard_scoreboard_fwd.sv - directed vector and sequence bench for hazard_scoreboard_fwd
module tb_hazard_scoreboard_fwd;

    localparam int WDOG = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_we, id_long;
    logic        ex_is_load;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic        ex_use_rs1, ex_use_rs2;
    logic [1:0]  stg_we;
    logic [9:0]  stg_rd;
    logic        lc_valid;
    logic [4:0]  lc_rd;
    logic        stall_id;
    logic [1:0]  rs1_fwd, rs2_fwd;
    logic [31:0] pending;
    logic        sb_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_scoreboard_fwd #(.NSTG(2), .NREG(32), .RW(5), .FW(2), .WDOG(WDOG)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_long(id_long),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
        .stg_we(stg_we), .stg_rd(stg_rd), .lc_valid(lc_valid), .lc_rd(lc_rd),
        .stall_id(stall_id), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .pending(pending), .sb_timeout(sb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] we;
        logic [9:0] rd;
        logic [4:0] xr1;
        logic [4:0] xr2;
        logic       xu1;
        logic       xu2;
        logic       ld;
        logic [4:0] xrd;
        logic       iv;
        logic [4:0] ir1;
        logic [4:0] ir2;
        logic       iu1;
        logic       iu2;
        logic       fl;
        logic [1:0] e1;
        logic [1:0] e2;
        logic       es;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_we = 0; id_long = 0;
        ex_is_load = 0; ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0; ex_use_rs1 = 0; ex_use_rs2 = 0;
        stg_we = 0; stg_rd = 0; lc_valid = 0; lc_rd = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle_inputs();
        id_valid = 1; id_rd = rd; id_we = 1; id_long = 1;
        tick();
        idle_inputs();
    endtask

    initial begin
        //            we     rd               xr1 xr2 xu1 xu2 ld xrd iv ir1 ir2 iu1 iu2 fl e1 e2 es
        vecs[0]  = '{2'b11, {5'd3, 5'd3},   3,  3,  1,  0,  0, 0,  0, 0,  0,  0,  0,  0, 1, 0, 0};
        vecs[1]  = '{2'b10, {5'd3, 5'd3},   3,  3,  1,  0,  0, 0,  0, 0,  0,  0,  0,  0, 2, 0, 0};
        vecs[2]  = '{2'b11, {5'd0, 5'd0},   0,  0,  1,  1,  0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 0};
        vecs[3]  = '{2'b11, {5'd3, 5'd3},   3,  3,  0,  1,  0, 0,  0, 0,  0,  0,  0,  0, 0, 1, 0};
        vecs[4]  = '{2'b01, {5'd4, 5'd6},   4,  6,  1,  1,  0, 0,  0, 0,  0,  0,  0,  0, 0, 1, 0};
        vecs[5]  = '{2'b11, {5'd4, 5'd6},   4,  6,  1,  1,  0, 0,  0, 0,  0,  0,  0,  0, 2, 1, 0};
        vecs[6]  = '{2'b00, {5'd0, 5'd0},   0,  0,  0,  0,  1, 7,  1, 0,  7,  0,  1,  0, 0, 0, 1};
        vecs[7]  = '{2'b00, {5'd0, 5'd0},   0,  0,  0,  0,  1, 7,  1, 0,  7,  0,  0,  0, 0, 0, 0};
        vecs[8]  = '{2'b00, {5'd0, 5'd0},   0,  0,  0,  0,  1, 0,  1, 0,  0,  0,  1,  0, 0, 0, 0};
        vecs[9]  = '{2'b00, {5'd0, 5'd0},   0,  0,  0,  0,  1, 7,  0, 0,  7,  0,  1,  0, 0, 0, 0};
        vecs[10] = '{2'b00, {5'd0, 5'd0},   0,  0,  0,  0,  1, 7,  1, 0,  7,  0,  1,  1, 0, 0, 0};
        vecs[11] = '{2'b00, {5'd0, 5'd0},   0,  0,  0,  0,  1, 12, 1, 12, 0,  1,  0,  0, 0, 0, 1};
        vecs[12] = '{2'b00, {5'd0, 5'd0},   0,  0,  0,  0,  0, 12, 1, 12, 0,  1,  0,  0, 0, 0, 0};

        idle_inputs();
        rst = 1;
        // Hazard-looking inputs during reset must still read 0.
        ex_is_load = 1; ex_rd = 7; id_valid = 1; id_rs2 = 7; id_use_rs2 = 1;
        stg_we = 2'b11; stg_rd = {5'd3, 5'd3}; ex_rs1 = 3; ex_use_rs1 = 1;
        tick();
        check("reset_stall", 32'(stall_id), 0);
        check("reset_rs1_fwd", 32'(rs1_fwd), 0);
        check("reset_pending", pending, 0);
        check("reset_timeout", 32'(sb_timeout), 0);
        rst = 0;
        idle_inputs();
        tick();

        for (int k = 0; k < 13; k++) begin
            stg_we = vecs[k].we; stg_rd = vecs[k].rd;
            ex_rs1 = vecs[k].xr1; ex_rs2 = vecs[k].xr2;
            ex_use_rs1 = vecs[k].xu1; ex_use_rs2 = vecs[k].xu2;
            ex_is_load = vecs[k].ld; ex_rd = vecs[k].xrd;
            id_valid = vecs[k].iv; id_rs1 = vecs[k].ir1; id_rs2 = vecs[k].ir2;
            id_use_rs1 = vecs[k].iu1; id_use_rs2 = vecs[k].iu2; flush = vecs[k].fl;
            #1;
            check($sformatf("vec%0d_rs1_fwd", k), 32'(rs1_fwd), 32'(vecs[k].e1));
            check($sformatf("vec%0d_rs2_fwd", k), 32'(rs2_fwd), 32'(vecs[k].e2));
            check($sformatf("vec%0d_stall", k), 32'(stall_id), 32'(vecs[k].es));
            tick();
        end
        idle_inputs();
        check("vec_no_pending", pending, 0);

        // Load-use lasts one cycle once the load leaves EX.
        ex_is_load = 1; ex_rd = 7; id_valid = 1; id_rs2 = 7; id_use_rs2 = 1;
        #1 check("lu_stall", 32'(stall_id), 1);
        tick();
        ex_is_load = 0;
        #1 check("lu_release", 32'(stall_id), 0);
        tick();
        idle_inputs();

        // Scoreboard RAW and completion bypass.
        issue_long(9);
        check("sb_pending9", pending, 32'h200);
        id_valid = 1; id_rs1 = 9; id_use_rs1 = 1;
        #1 check("sb_stall", 32'(stall_id), 1);
        tick();
        check("sb_stall_hold", 32'(stall_id), 1);
        lc_valid = 1; lc_rd = 9;
        #1 check("sb_complete_nostall", 32'(stall_id), 0);
        tick();
        idle_inputs();
        check("sb_cleared9", pending, 0);

        // WAW on a pending destination.
        issue_long(10);
        id_valid = 1; id_rd = 10; id_we = 1;
        #1 check("waw_stall", 32'(stall_id), 1);
        idle_inputs();
        lc_valid = 1; lc_rd = 10;
        tick();
        idle_inputs();

        // Simultaneous set and clear: set wins; stray completion and x0 ignored.
        issue_long(5);
        id_valid = 1; id_rd = 5; id_we = 1; id_long = 1; lc_valid = 1; lc_rd = 5;
        #1 check("setclr_nostall", 32'(stall_id), 0);
        tick();
        idle_inputs();
        check("setclr_pending5", pending, 32'h20);
        lc_valid = 1; lc_rd = 6;
        tick();
        idle_inputs();
        check("lc_nonpending", pending, 32'h20);
        issue_long(0);
        check("x0_never_pending", pending, 32'h20);
        lc_valid = 1; lc_rd = 5;
        tick();
        idle_inputs();
        check("clear5", pending, 0);

        // Watchdog with a flush mid-WAIT restarting the count.
        do_reset();
        issue_long(4);
        id_valid = 1; id_rs2 = 4; id_use_rs2 = 1;
        for (int c = 0; c < 5; c++) tick();
        flush = 1;
        #1 check("flush_nostall", 32'(stall_id), 0);
        tick();
        flush = 0;
        check("flush_keeps_pending", pending, 32'h10);
        for (int c = 0; c < WDOG; c++) tick();
        check("wdog_not_yet", 32'(sb_timeout), 0);
        tick();
        check("wdog_fired", 32'(sb_timeout), 1);
        id_valid = 0;
        tick();
        check("wdog_sticky", 32'(sb_timeout), 1);

        // Reset mid-WAIT.
        id_valid = 1;
        tick();
        tick();
        rst = 1;
        #1 check("rst_stall_zero", 32'(stall_id), 0);
        tick();
        rst = 0;
        check("rst_pending", pending, 0);
        check("rst_timeout", 32'(sb_timeout), 0);
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
